// File: rtl/menu_ctrl.sv
// Menu/mode controller between four push-buttons and the VGA display datapath.
// Each button is optionally inverted, synchronised through two flops and
// debounced; debounced press edges drive a two-state menu FSM. The mode and
// cursor codes seen by the display are refreshed only on frame_start, so the
// picture never changes mid-frame.
//
// Button bit order everywhere: {up, down, left, right} = [3:0].
module menu_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NUM_ITEMS       = 3,
  parameter int BTN_ACTIVE_LOW  = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       button_up_in,
  input  logic       button_down_in,
  input  logic       button_left_in,
  input  logic       button_right_in,
  input  logic       frame_start,
  output logic [1:0] state_output,
  output logic [1:0] cursor_output,
  output logic [3:0] press_evt
);

  // Counter is just wide enough to hold DEBOUNCE_CYCLES-1, so it never wraps.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]    LAST_ITEM = 2'(NUM_ITEMS - 1);

  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_DOWN  = 2;
  localparam int B_UP    = 3;

  typedef enum logic {
    ST_MENU = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [3:0]    w_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_stable;
  logic [3:0]    r_stable_q;
  logic [CW-1:0] r_cnt [4];
  logic [3:0]    r_evt;

  state_t        r_state;
  logic [1:0]    r_mode;
  logic [1:0]    r_cursor;
  logic [1:0]    r_disp_mode;
  logic [1:0]    r_disp_cursor;

  // Pressed buttons read as 1 after this point regardless of board polarity.
  assign w_raw = (BTN_ACTIVE_LOW != 0) ?
                 ~{button_up_in, button_down_in, button_left_in, button_right_in} :
                  {button_up_in, button_down_in, button_left_in, button_right_in};

  // Synchronise, debounce and edge-detect all four buttons.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_q <= '0;
      r_evt      <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      // Only a released->pressed transition of the accepted level is an event.
      r_evt      <= r_stable & ~r_stable_q;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Menu FSM: one event per cycle, priority right > left > up > down.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state  <= ST_MENU;
      r_mode   <= 2'd0;
      r_cursor <= 2'd0;
    end else begin
      case (r_state)
        ST_MENU: begin
          if (r_evt[B_RIGHT]) begin
            r_state <= ST_RUN;
            r_mode  <= r_cursor + 2'd1;
          end else if (r_evt[B_LEFT]) begin
            // Back has no meaning in the menu; it still masks up/down.
            r_state <= ST_MENU;
          end else if (r_evt[B_UP]) begin
            r_cursor <= (r_cursor == 2'd0) ? LAST_ITEM : r_cursor - 2'd1;
          end else if (r_evt[B_DOWN]) begin
            r_cursor <= (r_cursor == LAST_ITEM) ? 2'd0 : r_cursor + 2'd1;
          end
        end
        ST_RUN: begin
          // A right press outranks left even though it is ignored here.
          if (!r_evt[B_RIGHT] && r_evt[B_LEFT]) begin
            r_state <= ST_MENU;
            r_mode  <= 2'd0;
          end
        end
        default: begin
          r_state <= ST_MENU;
          r_mode  <= 2'd0;
        end
      endcase
    end
  end

  // Display copy follows the internal codes only at a frame boundary.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_disp_mode   <= 2'd0;
      r_disp_cursor <= 2'd0;
    end else if (frame_start) begin
      r_disp_mode   <= r_mode;
      r_disp_cursor <= r_cursor;
    end
  end

  assign state_output  = r_disp_mode;
  assign cursor_output = r_disp_cursor;
  assign press_evt     = r_evt;

endmodule

// File: tb/tb_menu_ctrl.sv
// Directed bench for menu_ctrl with a short debounce window (4 cycles) and
// three menu items. Inputs change and outputs are sampled on the falling edge.
module tb_menu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;   // {up, down, left, right}
  logic       frame;
  logic [1:0] state_o;
  logic [1:0] cursor_o;
  logic [3:0] evt;

  int n_checks = 0;
  int n_err    = 0;
  int evt_cnt;
  logic [3:0] evt_last;
  int evt_at;

  menu_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .NUM_ITEMS      (3),
    .BTN_ACTIVE_LOW (0)
  ) dut (
    .sys_clk        (clk),
    .sys_rst        (rst),
    .button_up_in   (btn[3]),
    .button_down_in (btn[2]),
    .button_left_in (btn[1]),
    .button_right_in(btn[0]),
    .frame_start    (frame),
    .state_output   (state_o),
    .cursor_output  (cursor_o),
    .press_evt      (evt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tick n cycles, counting cycles with any press event.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (evt != 4'b0) begin
        evt_cnt++;
        evt_last = evt;
      end
    end
  endtask

  // Clean press of the buttons in mask, held long enough, then released.
  task automatic press(input logic [3:0] mask);
    evt_cnt  = 0;
    evt_last = 4'b0;
    btn = mask;
    watch(10);
    btn = 4'b0;
    watch(10);
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    btn   = 4'b0;
    frame = 1'b0;
    @(negedge clk);
    tick(); tick();
    chk("rst_state", 8'(state_o), 8'd0);
    chk("rst_cursor", 8'(cursor_o), 8'd0);
    chk("rst_evt", 8'(evt), 8'd0);
    rst = 1'b0;
    tick();

    // Latency: down held 10 cycles, event expected after the 7th edge.
    evt_cnt = 0; evt_at = 0;
    btn = 4'b0100;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (evt != 4'b0) begin
        evt_cnt++;
        evt_at = i;
        chk("lat_evt_val", 8'(evt), 8'h04);
      end
    end
    btn = 4'b0;
    watch(10);
    chk("lat_evt_cnt", 8'(evt_cnt), 8'd1);
    chk("lat_evt_at", 8'(evt_at), 8'd7);
    chk("lat_no_frame", 8'(cursor_o), 8'd0);
    pulse_frame();
    chk("lat_cursor", 8'(cursor_o), 8'd1);

    // Bounce 1,0,1,0 every 2 cycles then held: one event, cursor 1 -> 2.
    evt_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      btn = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      watch(2);
    end
    btn = 4'b0100;
    watch(10);
    btn = 4'b0;
    watch(10);
    chk("bounce_cnt", 8'(evt_cnt), 8'd1);
    pulse_frame();
    chk("bounce_cursor", 8'(cursor_o), 8'd2);

    // Up glitch of 3 cycles: no event, cursor stays 2.
    evt_cnt = 0;
    btn = 4'b1000;
    watch(3);
    btn = 4'b0;
    watch(12);
    chk("glitch_cnt", 8'(evt_cnt), 8'd0);
    pulse_frame();
    chk("glitch_cursor", 8'(cursor_o), 8'd2);

    // Wraps: down from 2 -> 0, up from 0 -> 2, up -> 1.
    press(4'b0100);
    pulse_frame();
    chk("wrap_down", 8'(cursor_o), 8'd0);
    press(4'b1000);
    chk("up_evt", 8'(evt_last), 8'h08);
    pulse_frame();
    chk("wrap_up", 8'(cursor_o), 8'd2);
    press(4'b1000);
    pulse_frame();
    chk("up_to1", 8'(cursor_o), 8'd1);

    // Confirm item 1 -> mode 2, shown only after frame_start.
    press(4'b0001);
    chk("run_pre_frame", 8'(state_o), 8'd0);
    pulse_frame();
    chk("run_state", 8'(state_o), 8'd2);
    chk("run_cursor", 8'(cursor_o), 8'd1);
    press(4'b1000);
    pulse_frame();
    chk("run_up_ign_st", 8'(state_o), 8'd2);
    chk("run_up_ign_cur", 8'(cursor_o), 8'd1);
    press(4'b0010);
    pulse_frame();
    chk("back_state", 8'(state_o), 8'd0);
    chk("back_cursor", 8'(cursor_o), 8'd1);

    // Up and right together in MENU: right wins, cursor unchanged.
    press(4'b1001);
    chk("simul_evt", 8'(evt_last), 8'h09);
    chk("simul_evt_cnt", 8'(evt_cnt), 8'd1);
    pulse_frame();
    chk("simul_state", 8'(state_o), 8'd2);
    chk("simul_cursor", 8'(cursor_o), 8'd1);
    press(4'b0010);
    pulse_frame();
    chk("simul_back", 8'(state_o), 8'd0);

    // frame_start on the same edge as the FSM change shows the old cursor.
    btn = 4'b0100;
    for (int i = 0; i < 7; i++) tick();
    chk("edge_evt", 8'(evt), 8'h04);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk("edge_old_cursor", 8'(cursor_o), 8'd1);
    btn = 4'b0;
    watch(10);
    pulse_frame();
    chk("edge_new_cursor", 8'(cursor_o), 8'd2);

    // Two changes in one frame: only the last is displayed (2 -> 0 -> 1).
    press(4'b0100);
    press(4'b0100);
    chk("multi_hold", 8'(cursor_o), 8'd2);
    pulse_frame();
    chk("multi_cursor", 8'(cursor_o), 8'd1);

    // Confirm then reset before the next frame: everything back to menu/0.
    press(4'b0001);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst2_state", 8'(state_o), 8'd0);
    chk("rst2_cursor", 8'(cursor_o), 8'd0);
    pulse_frame();
    chk("rst2_state_f", 8'(state_o), 8'd0);
    chk("rst2_cursor_f", 8'(cursor_o), 8'd0);
    press(4'b0100);
    pulse_frame();
    chk("rst2_menu_down", 8'(cursor_o), 8'd1);
    chk("rst2_menu_st", 8'(state_o), 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
